// File: rtl/microwave_timer_ctrl_if.sv
// Signal bundle between the keypad/button front end, the mm:ss timer chain
// and the microwave sequencing controller.
interface microwave_timer_ctrl_if;
  // Front end and timer chain toward the controller
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        timer_zero;
  // Controller toward the timer chain, magnetron and display
  logic        timer_loadn;
  logic        timer_clearn;
  logic        timer_en;
  logic [15:0] load_data;
  logic        magnetron_on;
  logic        done;
  logic [2:0]  state;

  // Front-end side: drives keys/buttons/flags, observes controller outputs
  modport master (
    output key_valid, key_digit, start, stop, door_closed, timer_zero,
    input  timer_loadn, timer_clearn, timer_en, load_data, magnetron_on, done, state
  );

  // Controller side
  modport slave (
    input  key_valid, key_digit, start, stop, door_closed, timer_zero,
    output timer_loadn, timer_clearn, timer_en, load_data, magnetron_on, done, state
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Microwave countdown sequencing controller. Collects keypad digits into a
// 4-digit BCD entry register (mm:ss), loads it into the external timer chain,
// gates the chain enable and the magnetron, and handles pause, door-open,
// stop and cook-complete. The timer chain only reports its all-zero flag.
module microwave_timer_ctrl #(
  parameter int unsigned DONE_CYCLES = 5
) (
  input logic                  clock,
  input logic                  clear,
  microwave_timer_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(DONE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StEntry = 3'd1,
    StLoad  = 3'd2,
    StCook  = 3'd3,
    StPause = 3'd4,
    StDone  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       entry_q, entry_d;
  logic [CntW-1:0]   done_cnt_q, done_cnt_d;

  logic              key_ok;
  logic [15:0]       entry_shift;
  logic              entry_nonzero;
  logic              resume_ok;

  // A digit is only taken if it is decimal and the current sec_ones will
  // become a legal sec_tens (0..5) for the mod-6 stage after the shift.
  assign key_ok        = bus.key_valid && (bus.key_digit <= 4'd9) && (entry_q[3:0] <= 4'd5);
  assign entry_shift   = {entry_q[11:0], bus.key_digit};
  assign entry_nonzero = (entry_q != 16'h0000);
  assign resume_ok     = bus.start && bus.door_closed;

  // Next-state and entry-register logic
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    unique case (state_q)
      StIdle: begin
        if (key_ok) begin
          state_d = StEntry;
          entry_d = entry_shift;
        end
      end
      StEntry: begin
        // start/stop outrank a simultaneous key; an ineffective start does not
        if (bus.stop) begin
          state_d = StIdle;
          entry_d = 16'h0000;
        end else if (resume_ok && entry_nonzero) begin
          state_d = StLoad;
        end else if (key_ok) begin
          entry_d = entry_shift;
        end
      end
      StLoad: begin
        state_d = StCook;
      end
      StCook: begin
        // Reaching zero wins over a door opening or stop in the same cycle
        if (bus.timer_zero) begin
          state_d = StDone;
        end else if (bus.stop || !bus.door_closed) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (bus.stop) begin
          state_d = StIdle;
          entry_d = 16'h0000;
        end else if (resume_ok) begin
          // Timer chain still holds its count, so no reload on resume
          state_d = StCook;
        end
      end
      StDone: begin
        if (bus.stop || (done_cnt_q == CntLast)) begin
          state_d = StIdle;
          entry_d = 16'h0000;
        end
      end
      default: begin
        state_d = StIdle;
        entry_d = 16'h0000;
      end
    endcase
  end

  // Done counter: held at zero outside DONE so it starts from zero on entry
  always_comb begin
    done_cnt_d = '0;
    if (state_q == StDone) begin
      done_cnt_d = done_cnt_q + CntW'(1);
    end
  end

  // State, entry and done-counter registers with synchronous clear
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= StIdle;
      entry_q    <= 16'h0000;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Moore output decode from the current state
  always_comb begin
    bus.timer_loadn  = 1'b1;
    bus.timer_clearn = 1'b1;
    bus.timer_en     = 1'b0;
    bus.magnetron_on = 1'b0;
    bus.done         = 1'b0;
    unique case (state_q)
      StIdle:  bus.timer_clearn = 1'b0;
      StEntry: bus.timer_clearn = 1'b1;
      StLoad:  bus.timer_loadn  = 1'b0;
      StCook: begin
        bus.timer_en     = 1'b1;
        bus.magnetron_on = 1'b1;
      end
      StPause: bus.timer_en = 1'b0;
      StDone:  bus.done     = 1'b1;
      default: bus.timer_clearn = 1'b1;
    endcase
  end

  assign bus.load_data = entry_q;
  assign bus.state     = state_q;

endmodule
